fixedpoint_multiplication: RTL

FIXEDPOINT_MULTIPLICATION -- requirements
Module: fixedpoint_multiplication

---
 rtl/fixedpoint_multiplication.sv | 130 +++++++++++++
 1 files changed

// File: rtl/fixedpoint_multiplication.sv
// Sequential sign-magnitude fixed-point multiplier: one shift-add step per clock,
// truncating the product back to the operand format with saturation on overflow.
module fixedpoint_multiplication #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic [WIDTH-1:0] product_out,
    output logic             overflow,
    output logic             busy,
    output logic             finished
);

    // state | meaning
    // IDLE  | waiting for enable; last result held on the outputs
    // RUN   | one shift-add step per clock, WIDTH-1 clocks total
    // DONE  | result formatted and registered, finished pulse raised
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int MW = WIDTH - 1;
    localparam int AW = 2 * MW;
    localparam int CW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic             sign_q, sign_d;
    logic [MW-1:0]    mplier_q, mplier_d;
    logic [AW-1:0]    addend_q, addend_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] product_q, product_d;
    logic             overflow_q, overflow_d;
    logic             busy_q, busy_d;
    logic             finished_q, finished_d;

    logic [AW-1:0]    acc_scaled;
    logic [AW-1:0]    acc_high;
    logic             ovf_c;
    logic [MW-1:0]    mag_c;

    // Keep the window [MW-1+FRAC : FRAC]; anything above it saturates.
    assign acc_scaled = acc_q >> FRAC;
    assign acc_high   = acc_q >> (MW + FRAC);
    assign ovf_c      = |acc_high;
    assign mag_c      = ovf_c ? {MW{1'b1}} : acc_scaled[MW-1:0];

    always_comb begin
        state_d    = state_q;
        sign_d     = sign_q;
        mplier_d   = mplier_q;
        addend_d   = addend_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        product_d  = product_q;
        overflow_d = overflow_q;
        busy_d     = busy_q;
        finished_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    sign_d   = multiplicand[WIDTH-1] ^ multiplier[WIDTH-1];
                    mplier_d = multiplier[MW-1:0];
                    addend_d = {{MW{1'b0}}, multiplicand[MW-1:0]};
                    acc_d    = '0;
                    cnt_d    = CW'(MW - 1);
                    busy_d   = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + addend_q;
                end
                mplier_d = mplier_q >> 1;
                addend_d = addend_q << 1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                product_d  = {sign_q & (|mag_c), mag_c};
                overflow_d = ovf_c;
                finished_d = 1'b1;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sign_q     <= 1'b0;
            mplier_q   <= '0;
            addend_q   <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            product_q  <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            finished_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sign_q     <= sign_d;
            mplier_q   <= mplier_d;
            addend_q   <= addend_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            product_q  <= product_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            finished_q <= finished_d;
        end
    end

    assign product_out = product_q;
    assign overflow    = overflow_q;
    assign busy        = busy_q;
    assign finished    = finished_q;

endmodule
